// File: rtl/clk_div_pkg.sv
// Shared constants and types for the multi-channel clock divider.
package clk_div_pkg;
  localparam int DFLT_CNT_W = 28;
  localparam logic [DFLT_CNT_W-1:0] DFLT_DIV = 28'd50_000_000;
  // Shorter periods are stretched to this many cycles.
  localparam int MIN_DIV = 2;

  typedef struct packed {
    logic [DFLT_CNT_W-1:0] div;
    logic [DFLT_CNT_W-1:0] high;
  } ch_cfg_t;
endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: double-buffered settings, period counter, registered clk/tick.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int               CNT_W    = DFLT_CNT_W,
  parameter logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DFLT_DIV),
  parameter logic [CNT_W-1:0] DEF_HIGH = DEF_DIV / 2
) (
  input  logic             clk_50M,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  input  logic [CNT_W-1:0] wr_high,
  input  logic             restart,
  output logic             clk_out,
  output logic             tick
);
  typedef struct packed {
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] high;
  } cfg_t;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           st_q, st_nxt;
  cfg_t             shadow_q, shadow_nxt, active_q, active_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt, ne_a;
  logic             wrap, tick_nxt, clk_nxt;

  function automatic logic [CNT_W-1:0] eff_div(input logic [CNT_W-1:0] n);
    return (n < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : n;
  endfunction

  // Low for the first N_e-H cycles; the guards keep N_e-H from underflowing.
  function automatic logic level(input logic [CNT_W-1:0] cnt, input cfg_t c);
    logic [CNT_W-1:0] ne;
    ne = eff_div(c.div);
    if (c.high == '0) return 1'b0;
    if (c.high >= ne) return 1'b1;
    return cnt >= (ne - c.high);
  endfunction

  always_comb begin
    shadow_nxt = wr ? cfg_t'{div: wr_div, high: wr_high} : shadow_q;
    ne_a       = eff_div(active_q.div);
    wrap       = (st_q == RUN) && (cnt_q == ne_a - CNT_W'(1));
    st_nxt     = st_q;
    cnt_nxt    = cnt_q;
    active_nxt = active_q;
    tick_nxt   = 1'b0;
    clk_nxt    = 1'b0;
    if (!en) begin
      st_nxt     = IDLE;
      cnt_nxt    = '0;
      active_nxt = shadow_nxt;
    end else if (st_q == IDLE || restart || wrap) begin
      st_nxt     = RUN;
      cnt_nxt    = '0;
      active_nxt = shadow_nxt;
      tick_nxt   = 1'b1;
      clk_nxt    = level('0, shadow_nxt);
    end else begin
      cnt_nxt = cnt_q + CNT_W'(1);
      clk_nxt = level(cnt_nxt, active_q);
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= IDLE;
      shadow_q <= cfg_t'{div: DEF_DIV, high: DEF_HIGH};
      active_q <= cfg_t'{div: DEF_DIV, high: DEF_HIGH};
      cnt_q    <= '0;
      tick     <= 1'b0;
      clk_out  <= 1'b0;
    end else begin
      st_q     <= st_nxt;
      shadow_q <= shadow_nxt;
      active_q <= active_nxt;
      cnt_q    <= cnt_nxt;
      tick     <= tick_nxt;
      clk_out  <= clk_nxt;
    end
  end
endmodule

// File: rtl/clk_div_multi.sv
// NUM_CH independent programmable dividers sharing one write port and restart.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int               NUM_CH   = 4,
  parameter int               CNT_W    = DFLT_CNT_W,
  parameter logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DFLT_DIV),
  parameter logic [CNT_W-1:0] DEF_HIGH = DEF_DIV / 2,
  localparam int              CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_50M,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  input  logic [CNT_W-1:0]  wr_high,
  input  logic              restart,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);
  logic [NUM_CH-1:0] wr_sel;

  // Out-of-range channel numbers match no channel and are dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_sel[i] = wr_en && (32'(wr_ch) == 32'(i));

    clk_div_channel #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV),
      .DEF_HIGH(DEF_HIGH)
    ) u_ch (
      .clk_50M(clk_50M),
      .rst_n  (rst_n),
      .en     (en[i]),
      .wr     (wr_sel[i]),
      .wr_div (wr_div),
      .wr_high(wr_high),
      .restart(restart),
      .clk_out(clk_out[i]),
      .tick   (tick[i])
    );
  end
endmodule
